// File: rtl/and_not_g_if.sv
// Valid-qualified operand/result bundle for the and_not_g gate cell.
// The producer drives the master side; the gate cell takes the slave side.
interface and_not_g_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [1:0]       op;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] and_o;
  logic             out_valid;
  logic             op_err;

  modport master (
    output in_valid, op, m, n,
    input  p, and_o, out_valid, op_err
  );

  modport slave (
    input  in_valid, op, m, n,
    output p, and_o, out_valid, op_err
  );
endinterface

// File: rtl/and_not_g.sv
// Registered AND/NOT/NAND gate cell; latency 1, or 2 with AND_NOT_G_PIPE_EN defined.
// One op per cycle, no backpressure: every out_valid must be taken by the consumer.
module and_not_g #(
  parameter int WIDTH = 1
) (
  input logic        clk,
  input logic        rst_n,
  and_not_g_if.slave bus
);
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_NOT  = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;

  logic [WIDTH-1:0] w_w1;
  logic             w_vld;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_node;
  logic [WIDTH-1:0] w_m;
  logic [WIDTH-1:0] w_p;
  logic             w_err;

  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_and;
  logic             r_vld;
  logic             r_err;

  assign w_w1 = bus.m & bus.n;

`ifdef AND_NOT_G_PIPE_EN
  logic             r_s1_vld;
  logic [1:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_w1;
  logic [WIDTH-1:0] r_s1_m;

  // Stage 1 captures the AND node plus what the NOT/select stage still needs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_op  <= 2'b00;
      r_s1_w1  <= '0;
      r_s1_m   <= '0;
    end else begin
      r_s1_vld <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_op <= bus.op;
        r_s1_w1 <= w_w1;
        r_s1_m  <= bus.m;
      end
    end
  end

  assign w_vld  = r_s1_vld;
  assign w_op   = r_s1_op;
  assign w_node = r_s1_w1;
  assign w_m    = r_s1_m;
`else
  assign w_vld  = bus.in_valid;
  assign w_op   = bus.op;
  assign w_node = w_w1;
  assign w_m    = bus.m;
`endif

  always_comb begin
    w_p   = '0;
    w_err = 1'b0;
    case (w_op)
      OP_AND:  w_p = w_node;
      OP_NOT:  w_p = ~w_m;
      OP_NAND: w_p = ~w_node;
      default: w_err = 1'b1;
    endcase
  end

  // Result registers only load on a valid beat so they hold through gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p   <= '0;
      r_and <= '0;
      r_vld <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_vld <= w_vld;
      if (w_vld) begin
        r_p   <= w_p;
        r_and <= w_node;
        r_err <= w_err;
      end
    end
  end

  assign bus.p         = r_p;
  assign bus.and_o     = r_and;
  assign bus.out_valid = r_vld;
  assign bus.op_err    = r_err;
endmodule

// File: tb/tb_and_not_g.sv
// Directed bench for and_not_g: one WIDTH=1 and one WIDTH=8 instance on a shared clock/reset.
module tb_and_not_g;
`ifdef AND_NOT_G_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   idx;

  logic [3:0] nand_exp;
  logic [7:0] gap_p   [3];
  logic       gap_vld [3];
  logic [7:0] rm      [16];
  logic [7:0] rn      [16];
  logic [7:0] exp_p;

  and_not_g_if #(.WIDTH(1)) b1 ();
  and_not_g_if #(.WIDTH(8)) b8 ();

  and_not_g #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  and_not_g #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive8(input logic vld, input logic [1:0] op, input logic [7:0] m, input logic [7:0] n);
    b8.in_valid = vld;
    b8.op       = op;
    b8.m        = m;
    b8.n        = n;
  endtask

  // One op, then idle until its result has surfaced.
  task automatic run8(input logic [1:0] op, input logic [7:0] m, input logic [7:0] n);
    drive8(1'b1, op, m, n);
    tick();
    drive8(1'b0, 2'b00, 8'h00, 8'h00);
    for (int k = 1; k < LAT; k++) tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    b1.in_valid = 1'b0; b1.op = 2'b00; b1.m = 1'b0; b1.n = 1'b0;
    drive8(1'b0, 2'b00, 8'h00, 8'h00);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_p8",     b8.p,         0);
    chk("rst_and8",   b8.and_o,     0);
    chk("rst_vld8",   b8.out_valid, 0);
    chk("rst_err8",   b8.op_err,    0);
    chk("rst_p1",     b1.p,         0);
    chk("rst_vld1",   b1.out_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // NAND truth table on the 1-bit cell, back to back.
    nand_exp = 4'b0111;
    for (int i = 0; i < 4 + LAT; i++) begin
      if (i < 4) begin
        b1.in_valid = 1'b1; b1.op = 2'b10; b1.m = i[1]; b1.n = i[0];
      end else begin
        b1.in_valid = 1'b0;
      end
      tick();
      idx = i - (LAT - 1);
      if (idx >= 0 && idx < 4) begin
        chk("nand_vld", b1.out_valid, 1);
        chk("nand_p",   b1.p,         nand_exp[idx]);
      end else if (idx >= 4) begin
        chk("nand_idle_vld", b1.out_valid, 0);
      end
    end

    run8(2'b00, 8'hF0, 8'h3C);
    chk("and_p",   b8.p,         8'h30);
    chk("and_and", b8.and_o,     8'h30);
    chk("and_vld", b8.out_valid, 1);
    chk("and_err", b8.op_err,    0);
    run8(2'b10, 8'hF0, 8'h3C);
    chk("nand8_p",   b8.p,     8'hCF);
    chk("nand8_and", b8.and_o, 8'h30);
    run8(2'b01, 8'hA5, 8'hFF);
    chk("not_p",   b8.p,      8'h5A);
    chk("not_err", b8.op_err, 0);
    run8(2'b11, 8'hA5, 8'hFF);
    chk("ill_p",   b8.p,         8'h00);
    chk("ill_and", b8.and_o,     8'hA5);
    chk("ill_err", b8.op_err,    1);
    chk("ill_vld", b8.out_valid, 1);
    tick();
    chk("hold_vld", b8.out_valid, 0);
    chk("hold_p",   b8.p,         8'h00);
    chk("hold_err", b8.op_err,    1);

    // Gap: valid, idle, valid.
    gap_vld[0] = 1'b1; gap_vld[1] = 1'b0; gap_vld[2] = 1'b1;
    gap_p[0] = 8'h30;  gap_p[1] = 8'h30;  gap_p[2] = 8'h5A;
    for (int i = 0; i < 3 + LAT; i++) begin
      if (i == 0)      drive8(1'b1, 2'b00, 8'hF0, 8'h3C);
      else if (i == 2) drive8(1'b1, 2'b01, 8'hA5, 8'hFF);
      else             drive8(1'b0, 2'b00, 8'h00, 8'h00);
      tick();
      idx = i - (LAT - 1);
      if (idx >= 0 && idx < 3) begin
        chk("gap_vld", b8.out_valid, gap_vld[idx]);
        chk("gap_p",   b8.p,         gap_p[idx]);
      end
    end

    // Asynchronous reset while a result is in flight.
    drive8(1'b1, 2'b00, 8'hFF, 8'hFF);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_p",   b8.p,         0);
    chk("mid_rst_and", b8.and_o,     0);
    chk("mid_rst_vld", b8.out_valid, 0);
    drive8(1'b0, 2'b00, 8'h00, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_vld", b8.out_valid, 0);
    end
    @(negedge clk) rst_n = 1'b0;
    #2;
    // First valid on the very first edge after release is accepted.
    drive8(1'b1, 2'b10, 8'hF0, 8'h3C);
    @(negedge clk) rst_n = 1'b1;
    tick();
    drive8(1'b0, 2'b00, 8'h00, 8'h00);
    for (int k = 1; k < LAT; k++) tick();
    chk("first_vld", b8.out_valid, 1);
    chk("first_p",   b8.p,         8'hCF);

    // Alternating AND / NAND with random operands, back to back.
    for (int i = 0; i < 16; i++) begin
      rm[i] = 8'($urandom);
      rn[i] = 8'($urandom);
    end
    for (int i = 0; i < 16 + LAT; i++) begin
      if (i < 16) drive8(1'b1, i[0] ? 2'b10 : 2'b00, rm[i], rn[i]);
      else        drive8(1'b0, 2'b00, 8'h00, 8'h00);
      tick();
      idx = i - (LAT - 1);
      if (idx >= 0 && idx < 16) begin
        exp_p = idx[0] ? ~(rm[idx] & rn[idx]) : (rm[idx] & rn[idx]);
        chk("rnd_vld", b8.out_valid, 1);
        chk("rnd_p",   b8.p,         exp_p);
        chk("rnd_and", b8.and_o,     rm[idx] & rn[idx]);
        chk("rnd_err", b8.op_err,    0);
      end else if (idx >= 16) begin
        chk("rnd_tail_vld", b8.out_valid, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
